// File: rtl/mini_mips_pkg.sv
// Shared Mini-MIPS definitions: opcode field position, default instruction
// width and the fetch FSM state encoding.
package mini_mips_pkg;
  localparam int OPC_MSB     = 15;
  localparam int OPC_LSB     = 12;
  localparam int INSTR_W_DEF = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    FULL = 2'd2
  } fetch_state_t;
endpackage

// File: rtl/fetch_pc_reg.sv
// Program counter register: synchronous reset to RESET_PC, load beats
// increment, increment wraps modulo 2^ADDR_W.
module fetch_pc_reg #(
  parameter int                ADDR_W   = 8,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic              inc,
  input  logic [ADDR_W-1:0] load_pc,
  output logic [ADDR_W-1:0] pc
);
  logic [ADDR_W-1:0] pc_q, pc_d;

  always_comb begin
    pc_d = pc_q;
    if (load)     pc_d = load_pc;
    else if (inc) pc_d = pc_q + ADDR_W'(1);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) pc_q <= RESET_PC;
    else        pc_q <= pc_d;
  end

  assign pc = pc_q;
endmodule

// File: rtl/instruction_fetch.sv
// Mini-MIPS fetch stage: one outstanding request, one held instruction.
// Optional accepted-instruction counter enabled by FETCH_PERF_CNT_EN.
module instruction_fetch
  import mini_mips_pkg::*;
#(
  parameter int                ADDR_W   = 8,
  parameter int                INSTR_W  = INSTR_W_DEF,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic               clk,
  input  logic               rst_n,
  output logic               imem_req,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic               imem_ack,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic               if_valid,
  output logic [INSTR_W-1:0] if_instr,
  output logic [3:0]         if_opcode,
  output logic [ADDR_W-1:0]  if_pc,
  input  logic               if_ready,
  input  logic               redirect,
`ifdef FETCH_PERF_CNT_EN
  input  logic [ADDR_W-1:0]  redirect_pc,
  output logic [15:0]        perf_fetch_cnt
`else
  input  logic [ADDR_W-1:0]  redirect_pc
`endif
);
  fetch_state_t       state_q, state_d;
  logic               imem_req_q, imem_req_d;
  logic               if_valid_q, if_valid_d;
  logic [INSTR_W-1:0] if_instr_q, if_instr_d;
  logic [ADDR_W-1:0]  if_pc_q, if_pc_d;
  logic [ADDR_W-1:0]  pc;
  logic               pc_inc;

  fetch_pc_reg #(.ADDR_W(ADDR_W), .RESET_PC(RESET_PC)) u_pc (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (redirect),
    .inc     (pc_inc),
    .load_pc (redirect_pc),
    .pc      (pc)
  );

  // Redirect squashes whatever is held or in flight, including a same-cycle ack.
  always_comb begin
    state_d    = state_q;
    if_valid_d = if_valid_q;
    if_instr_d = if_instr_q;
    if_pc_d    = if_pc_q;
    pc_inc     = 1'b0;
    if (redirect) begin
      state_d    = IDLE;
      if_valid_d = 1'b0;
    end else begin
      case (state_q)
        IDLE: state_d = REQ;
        REQ: if (imem_ack) begin
          if_instr_d = imem_rdata;
          if_pc_d    = pc;
          if_valid_d = 1'b1;
          pc_inc     = 1'b1;
          state_d    = FULL;
        end
        FULL: if (if_ready) begin
          if_valid_d = 1'b0;
          state_d    = REQ;
        end
        default: state_d = IDLE;
      endcase
    end
    imem_req_d = (state_d == REQ);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      imem_req_q <= 1'b0;
      if_valid_q <= 1'b0;
      if_instr_q <= '0;
      if_pc_q    <= '0;
    end else begin
      state_q    <= state_d;
      imem_req_q <= imem_req_d;
      if_valid_q <= if_valid_d;
      if_instr_q <= if_instr_d;
      if_pc_q    <= if_pc_d;
    end
  end

  assign imem_req  = imem_req_q;
  assign imem_addr = pc;
  assign if_valid  = if_valid_q;
  assign if_instr  = if_instr_q;
  assign if_opcode = if_instr_q[OPC_MSB:OPC_LSB];
  assign if_pc     = if_pc_q;

`ifdef FETCH_PERF_CNT_EN
  // A transfer counts even when a redirect lands on the same edge.
  logic [15:0] perf_cnt_q, perf_cnt_d;

  always_comb begin
    perf_cnt_d = perf_cnt_q;
    if (if_valid_q && if_ready && perf_cnt_q != 16'hFFFF) perf_cnt_d = perf_cnt_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) perf_cnt_q <= '0;
    else        perf_cnt_q <= perf_cnt_d;
  end

  assign perf_fetch_cnt = perf_cnt_q;
`endif
endmodule

// File: doc/instruction_fetch.md
# instruction_fetch

Instruction fetch stage of the Mini-MIPS processor. Holds the program counter, issues requests to instruction memory, and presents one 16-bit instruction at a time to decode. Decode takes `if_opcode` (bits 15:12) straight into `main_control`. Execute can redirect the PC on a taken branch; the redirect also squashes the instruction the stage is holding or fetching.

## Interface

Parameters:

- `ADDR_W`, default 8: PC and instruction-memory word-address width.
- `INSTR_W`, default 16: instruction width. The opcode is always bits [15:12].
- `RESET_PC`, default 0: PC value loaded on reset.

Ports:

- `clk`  in  1: single clock. All logic is rising-edge.
- `rst_n`  in  1: reset, synchronous, active-low.
- `imem_req`  out  1: fetch request to instruction memory.
- `imem_addr`  out  ADDR_W: word address of the request. Equals the current PC.
- `imem_ack`  in  1: `imem_rdata` is valid for the outstanding request this cycle.
- `imem_rdata`  in  INSTR_W: fetched instruction.
- `if_valid`  out  1: instruction available to decode.
- `if_instr`  out  INSTR_W: held instruction.
- `if_opcode`  out  4: equals `if_instr[15:12]`. Feeds `main_control`.
- `if_pc`  out  ADDR_W: address of `if_instr`.
- `if_ready`  in  1: decode accepts the instruction this cycle.
- `redirect`  in  1: taken branch from execute.
- `redirect_pc`  in  ADDR_W: branch target.
- `perf_fetch_cnt`  out  16: accepted-instruction count. Present only with `FETCH_PERF_CNT_EN`.

## Operation

State machine states:

- **IDLE**: `imem_req`=0. Always moves to REQ on the next cycle.
- **REQ**: `imem_req`=1 and `imem_addr`=PC, both held stable until `imem_ack`.
  - On `imem_ack`: `if_instr`←`imem_rdata`, `if_pc`←PC, `if_valid`←1, PC←PC+1, go to FULL.
- **FULL**: `if_valid`=1. `if_instr` and `if_pc` are held stable.
  - When `if_ready`=1 (transfer): `if_valid`←0, go to REQ.

Rules:

- **Redirect priority**: `redirect`=1 overrides everything, in any state.
  - PC←`redirect_pc`, `if_valid`←0, go to IDLE.
  - An `imem_ack` in the same cycle is discarded.
  - A simultaneous `if_valid`&`if_ready` transfer still counts as accepted: decode took it.
- **PC arithmetic**: PC+1 is modulo 2^ADDR_W. PC=2^ADDR_W−1 wraps to 0.
- **Stray acks**: `imem_ack` outside REQ is ignored.
- **Stall**: `if_ready`=0 in FULL holds the stage indefinitely. No new request is issued.
- **Reset mid-operation**: `rst_n`=0 at any edge aborts the outstanding request. The next cycle shows reset values. Any late `imem_ack` is ignored because the state is IDLE.

## Timing

- **Reset values**:
  - state=IDLE, PC=`RESET_PC`.
  - `imem_req`=0, `imem_addr`=`RESET_PC`.
  - `if_valid`=0, `if_instr`=0, `if_opcode`=0, `if_pc`=0.
  - `perf_fetch_cnt`=0.
- **Start-up**: first edge with `rst_n`=1 moves to REQ. `imem_req`=1 with `imem_addr`=`RESET_PC` on the following cycle.
- **Latency**: `imem_ack` sampled at edge N gives `if_valid`=1 from edge N onward (registered).
- **Throughput**: zero-wait memory plus always-ready decode gives one instruction every 2 cycles (REQ, FULL). No request overlaps a held instruction.
- **Redirect penalty**: one IDLE cycle. The request to `redirect_pc` appears 2 cycles after `redirect` is sampled.
- All outputs are registered except `if_opcode`, which is a slice of `if_instr`.

## Configuration

- `FETCH_PERF_CNT_EN` defined:
  - `perf_fetch_cnt` exists and increments on every `if_valid`&`if_ready` edge.
  - It saturates at 16'hFFFF and clears on reset.
- Undefined: the port and counter are absent. All other behaviour is identical.

## Structure

- Shared package `mini_mips_pkg` holds:
  - `OPC_MSB`=15 and `OPC_LSB`=12.
  - the `INSTR_W` default.
  - enum `fetch_state_t` {IDLE, REQ, FULL}.
- One sub-module, `fetch_pc_reg`: PC register with synchronous reset to `RESET_PC`, load (redirect) and increment (ack). Load has priority over increment.

## Test plan

- **Reset and first fetch**: release `rst_n`, zero-wait memory returning 16'h1234 at address 0 → `imem_req`=1 with addr 0 at cycle 1. `if_valid`=1, `if_opcode`=4'h1, `if_pc`=0 at cycle 2.
- **Stall**: hold `if_ready`=0 for 5 cycles with an instruction held → `if_instr` and `if_pc` unchanged, `imem_req`=0 throughout. Raise `if_ready` → next request at addr 1.
- **Redirect**: `redirect`=1 with `redirect_pc`=8'h40 while in REQ with `imem_ack`=1 → acked data discarded, one IDLE cycle, then `imem_addr`=8'h40.
- **Wrap-around**: `RESET_PC`=8'hFF, fetch two instructions → `if_pc` sequence FF, 00.
- **Reset mid-fetch**: assert `rst_n`=0 in REQ with an ack 3 cycles later → all outputs at reset values. After release, the first request is to `RESET_PC`.
- **With `FETCH_PERF_CNT_EN`**: 10 accepted transfers plus 1 squashed-unaccepted instruction → `perf_fetch_cnt`=10.
